// File: rtl/native_mem_ctrl.sv
// native_mem_ctrl: slave on a picorv32-style native memory bus.
// Serves fetches, loads and stores from an on-chip word RAM after a fixed
// number of wait states, maps one console word onto a small byte FIFO, and
// answers anything else with a bus_error pulse alongside mem_ready.
module native_mem_ctrl #(
    parameter int          MEM_WORDS    = 1024,
    parameter int          WAIT_STATES  = 1,
    parameter string       INIT_FILE    = "",
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        bus_error,
    output logic        console_valid,
    output logic [7:0]  console_data,
    input  logic        console_ready
);
    localparam int AW  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int WCW = $clog2(WAIT_STATES + 2);
    localparam logic [31:0]    MEM_WORDS_U   = MEM_WORDS;
    localparam logic [PW:0]    FIFO_FULL_CNT = (PW + 1)'(FIFO_DEPTH);
    localparam logic [WCW-1:0] WAIT_LOAD     = WCW'(WAIT_STATES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

    state_t         state_q, state_d;
    logic [29:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [3:0]     wstrb_q, wstrb_d;
    logic           instr_q, instr_d;
    logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
    logic           ready_q, ready_d;
    logic           bus_error_q, bus_error_d;
    logic           rdata_sel_q, rdata_sel_d;   // 1: return the RAM read port
    logic [31:0]    rdata_q, rdata_d;           // non-RAM read value
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW:0]    count_q, count_d;
    logic [7:0]     con_data_q, con_data_d;

    logic [31:0]    ram [0:MEM_WORDS-1];
    logic [31:0]    ram_rdata_q;
    logic [7:0]     fifo_mem [0:FIFO_DEPTH-1];

    logic hit_ram, hit_con, is_write, fifo_full, fifo_empty;
    logic stall, service, ram_we, push, pop;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = &{1'b0, mem_addr[1:0]};

    // Decode of the latched request; the console word is data-only.
    assign hit_ram    = ({2'b00, addr_q} < MEM_WORDS_U);
    assign hit_con    = !hit_ram && (addr_q == CONSOLE_ADDR[31:2]) && !instr_q;
    assign is_write   = |wstrb_q;
    assign fifo_full  = (count_q == FIFO_FULL_CNT);
    assign fifo_empty = (count_q == '0);
    // A console store into a full FIFO waits in RESP until a slot is free.
    assign stall      = hit_con && is_write && fifo_full;
    assign service    = (state_q == ST_RESP) && !stall && reset;
    assign ram_we     = service && hit_ram && is_write;
    assign push       = service && hit_con && wstrb_q[0];
    assign pop        = !fifo_empty && console_ready;

    // Request FSM: capture in IDLE, count wait states, respond in RESP.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        instr_d     = instr_q;
        wait_cnt_d  = wait_cnt_q;
        ready_d     = 1'b0;
        bus_error_d = 1'b0;
        rdata_sel_d = rdata_sel_q;
        rdata_d     = rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_valid) begin
                    addr_d     = mem_addr[31:2];
                    wdata_d    = mem_wdata;
                    wstrb_d    = mem_wstrb;
                    instr_d    = mem_instr;
                    wait_cnt_d = WAIT_LOAD;
                    state_d    = (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                end
            end
            ST_WAIT: begin
                wait_cnt_d = wait_cnt_q - WCW'(1);
                if (wait_cnt_q == WCW'(1)) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (!stall) begin
                    ready_d     = 1'b1;
                    state_d     = ST_IDLE;
                    rdata_sel_d = hit_ram && !is_write;
                    rdata_d     = '0;
                    if (hit_con && !is_write) begin
                        rdata_d = {30'b0, fifo_full, fifo_empty};
                    end
                    bus_error_d = !hit_ram && !hit_con;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Console FIFO pointers, occupancy and the registered head byte.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push, pop})
            2'b10:   count_d = count_q + (PW + 1)'(1);
            2'b01:   count_d = count_q - (PW + 1)'(1);
            default: count_d = count_q;
        endcase
        // The byte being pushed becomes the head when it lands on the new read slot.
        if (count_d == '0) begin
            con_data_d = con_data_q;
        end else if (push && (wr_ptr_q == rd_ptr_d)) begin
            con_data_d = wdata_q[7:0];
        end else begin
            con_data_d = fifo_mem[rd_ptr_d];
        end
    end

    // Control and status registers; RAM and FIFO storage are not reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            instr_q     <= 1'b0;
            wait_cnt_q  <= '0;
            ready_q     <= 1'b0;
            bus_error_q <= 1'b0;
            rdata_sel_q <= 1'b0;
            rdata_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            con_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            instr_q     <= instr_d;
            wait_cnt_q  <= wait_cnt_d;
            ready_q     <= ready_d;
            bus_error_q <= bus_error_d;
            rdata_sel_q <= rdata_sel_d;
            rdata_q     <= rdata_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            con_data_q  <= con_data_d;
        end
    end

    // Word RAM: byte-lane writes and a registered read that tracks the latched address.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (ram_we && wstrb_q[i]) begin
                ram[addr_q[AW-1:0]][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
        ram_rdata_q <= ram[addr_q[AW-1:0]];
    end

    // Console FIFO storage.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= wdata_q[7:0];
        end
    end

    assign mem_ready     = ready_q;
    assign bus_error     = bus_error_q;
    assign mem_rdata     = rdata_sel_q ? ram_rdata_q : rdata_q;
    assign console_valid = !fifo_empty;
    assign console_data  = con_data_q;

endmodule
